// File: rtl/nal_packer_if.sv
// Byte-stream bundle around nal_packer: encoder-side input, Annex-B output
// with back-pressure, FIFO status and FSM state for observation.
interface nal_packer_if #(
  parameter int FIFOBITS = 6
);
  logic [7:0]        in_byte;
  logic              in_strobe;
  logic              in_done;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [FIFOBITS:0] fifo_level;
  logic              overflow;
  logic [2:0]        dbg_state;

  modport slave (
    input  in_byte, in_strobe, in_done, out_ready,
    output out_byte, out_valid, out_last, fifo_level, overflow, dbg_state
  );

  modport master (
    output in_byte, in_strobe, in_done, out_ready,
    input  out_byte, out_valid, out_last, fifo_level, overflow, dbg_state
  );
endinterface

// File: rtl/nal_packer.sv
// Annex-B packer: buffers encoder slice bytes in a FIFO, then emits start
// code, payload with emulation-prevention bytes and a trailing-zero 0x03.
module nal_packer #(
  parameter int FIFODEPTH = 64,
  parameter int FIFOBITS  = 6,
  parameter bit LONGSC    = 1'b1
) (
  input logic         clk,
  input logic         rst,
  nal_packer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SC, S_DATA, S_EPB, S_TAIL} state_t;
  localparam logic [1:0] SC_LAST = LONGSC ? 2'd3 : 2'd2;

  logic [9:0]        r_mem [FIFODEPTH];
  logic [FIFOBITS:0] r_wr_ptr, r_rd_ptr;
  logic              r_overflow;
  state_t            r_state, w_state_nxt;
  logic [1:0]        r_sc_idx, w_sc_idx_nxt;
  logic [1:0]        r_zcnt, w_zcnt_nxt;
  logic [7:0]        r_out_byte, w_out_byte_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_out_last, w_out_last_nxt;

  logic [FIFOBITS:0] w_level;
  logic              w_empty, w_full, w_push, w_pop, w_wr_en, w_adv;
  logic [9:0]        w_push_entry, w_head;
  logic              w_head_eos, w_head_data;
  logic [7:0]        w_head_byte;

  // Entry layout {eos, has_data, byte}; a done-only cycle pushes an empty eos marker.
  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_empty      = (w_level == '0);
  assign w_full       = w_level[FIFOBITS];
  assign w_push       = bus.in_strobe | bus.in_done;
  assign w_push_entry = {bus.in_done, bus.in_strobe, bus.in_strobe ? bus.in_byte : 8'h00};
  assign w_wr_en      = w_push & (~w_full | w_pop);
  assign w_head       = r_mem[r_rd_ptr[FIFOBITS-1:0]];
  assign w_head_eos   = w_head[9];
  assign w_head_data  = w_head[8];
  assign w_head_byte  = w_head[7:0];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[FIFOBITS-1:0]] <= w_push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (FIFOBITS+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (FIFOBITS+1)'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Output handshake: out_byte/out_last move only when out_valid is low or
  // the current byte is accepted (out_valid & out_ready); otherwise all hold.
  assign w_adv = ~r_out_valid | bus.out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_sc_idx_nxt    = r_sc_idx;
    w_zcnt_nxt      = r_zcnt;
    w_out_byte_nxt  = r_out_byte;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_pop           = 1'b0;
    if (w_adv) begin
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (!w_head_data) begin
              w_pop = 1'b1;
            end else begin
              w_state_nxt  = S_SC;
              w_sc_idx_nxt = 2'd0;
              w_zcnt_nxt   = 2'd0;
            end
          end
        end
        S_SC: begin
          w_out_valid_nxt = 1'b1;
          w_out_byte_nxt  = (r_sc_idx == SC_LAST) ? 8'h01 : 8'h00;
          w_sc_idx_nxt    = r_sc_idx + 2'd1;
          if (r_sc_idx == SC_LAST) begin
            w_state_nxt = S_DATA;
            w_zcnt_nxt  = 2'd0;
          end
        end
        S_DATA, S_EPB: begin
          if (!w_empty) begin
            if (!w_head_data) begin
              // Bare eos marker: a nonzero zcnt means the last emitted byte was 0x00.
              w_pop       = 1'b1;
              w_state_nxt = (r_zcnt != 2'd0) ? S_TAIL : S_IDLE;
            end else if (r_zcnt == 2'd2 && w_head_byte <= 8'h03) begin
              w_out_valid_nxt = 1'b1;
              w_out_byte_nxt  = 8'h03;
              w_zcnt_nxt      = 2'd0;
              w_state_nxt     = S_EPB;
            end else begin
              w_pop           = 1'b1;
              w_out_valid_nxt = 1'b1;
              w_out_byte_nxt  = w_head_byte;
              w_state_nxt     = S_DATA;
              if (w_head_byte == 8'h00)
                w_zcnt_nxt = (r_zcnt == 2'd2) ? 2'd2 : r_zcnt + 2'd1;
              else
                w_zcnt_nxt = 2'd0;
              if (w_head_eos) begin
                if (w_head_byte != 8'h00) begin
                  w_out_last_nxt = 1'b1;
                  w_state_nxt    = S_IDLE;
                end else begin
                  w_state_nxt = S_TAIL;
                end
              end
            end
          end
        end
        S_TAIL: begin
          w_out_valid_nxt = 1'b1;
          w_out_byte_nxt  = 8'h03;
          w_out_last_nxt  = 1'b1;
          w_zcnt_nxt      = 2'd0;
          w_state_nxt     = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sc_idx    <= 2'd0;
      r_zcnt      <= 2'd0;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sc_idx    <= w_sc_idx_nxt;
      r_zcnt      <= w_zcnt_nxt;
      r_out_byte  <= w_out_byte_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign bus.out_byte   = r_out_byte;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.fifo_level = w_level;
  assign bus.overflow   = r_overflow;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_nal_packer.sv
// Bench for nal_packer: queue scoreboard fed by an Annex-B reference model,
// checked by negedge monitors on a 4-byte and a 3-byte start-code instance.
module tb_nal_packer;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;
  int   rdy_cnt = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_s_q[$];
  logic [8:0] mon_e;
  logic [8:0] mon_s_e;
  logic [9:0] held;
  logic       stalled_prev = 1'b0;

  nal_packer_if #(.FIFOBITS(6)) bus ();
  nal_packer_if #(.FIFOBITS(6)) bus_s ();

  nal_packer #(.FIFODEPTH(64), .FIFOBITS(6), .LONGSC(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  nal_packer #(.FIFODEPTH(64), .FIFOBITS(6), .LONGSC(1'b0)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Annex-B reference: start code, 0x03 before any 00..03 byte that follows two
  // zeros, last flag on the final byte, or a 0x03 tail when the NAL ends in 0x00.
  // ending: 0 = unfinished, 1 = done with last byte, 2 = separate done-only.
  function automatic void model_nal(input logic [7:0] p[$], input int ending,
                                    input bit longsc, output logic [8:0] o[$]);
    int z;
    logic [8:0] t;
    o = {};
    z = 0;
    if (longsc) o.push_back(9'h000);
    o.push_back(9'h000);
    o.push_back(9'h000);
    o.push_back(9'h001);
    foreach (p[i]) begin
      if (z == 2 && p[i] <= 8'h03) begin
        o.push_back(9'h003);
        z = 0;
      end
      o.push_back({1'b0, p[i]});
      z = (p[i] == 8'h00) ? ((z == 2) ? 2 : z + 1) : 0;
    end
    if (ending != 0 && p.size() > 0) begin
      if (p[p.size()-1] == 8'h00) begin
        o.push_back(9'h103);
      end else if (ending == 1) begin
        t = o.pop_back();
        t[8] = 1'b1;
        o.push_back(t);
      end
    end
  endfunction

  // driver tasks
  task automatic set_in(input logic [7:0] b, input logic s, input logic d);
    bus.in_byte   = b;
    bus.in_strobe = s;
    bus.in_done   = d;
  endtask

  task automatic send_nal(input logic [7:0] p[$], input int ending);
    logic [8:0] tmp[$];
    model_nal(p, ending, 1'b1, tmp);
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
    foreach (p[i]) begin
      set_in(p[i], 1'b1, (ending == 1) && (i == p.size() - 1));
      tick();
    end
    if (ending == 2) begin
      set_in(8'h00, 1'b0, 1'b1);
      tick();
    end
    set_in(8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: %0d bytes still expected after %0d cycles, expected 0", name, exp_q.size(), budget);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 8'h00;
    if (r < 7) return 8'($urandom_range(1, 3));
    return 8'($urandom_range(0, 255));
  endfunction

  // sink ready pattern
  initial begin
    bus.out_ready   = 1'b1;
    bus_s.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = (rdy_cnt == 0);
          rdy_cnt = (rdy_cnt + 1) % 3;
        end
        2: bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst && stalled_prev)
      check("stall_hold", 32'({bus.out_valid, bus.out_last, bus.out_byte}), 32'(held));
    stalled_prev = rst && bus.out_valid && !bus.out_ready;
    held = {bus.out_valid, bus.out_last, bus.out_byte};
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_extra: got %0h, expected no output", {bus.out_last, bus.out_byte});
      end else begin
        mon_e = exp_q.pop_front();
        check("out_byte", 32'({bus.out_last, bus.out_byte}), 32'(mon_e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus_s.out_valid && bus_s.out_ready) begin
      if (exp_s_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL short_extra: got %0h, expected no output", {bus_s.out_last, bus_s.out_byte});
      end else begin
        mon_s_e = exp_s_q.pop_front();
        check("short_out_byte", 32'({bus_s.out_last, bus_s.out_byte}), 32'(mon_s_e));
      end
    end
  end

  initial begin
    logic [7:0] pl[$];
    logic [8:0] tmp[$];
    int n;

    rst = 1'b0;
    set_in(8'h00, 1'b0, 1'b0);
    bus_s.in_byte = 8'h00;
    bus_s.in_strobe = 1'b0;
    bus_s.in_done = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_out_byte", 32'(bus.out_byte), 0);
    check("rst_fifo_level", 32'(bus.fifo_level), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_state", 32'(bus.dbg_state), 0);
    rst = 1'b1;
    tick();

    // single NAL with first-output latency
    pl = {8'h65, 8'h88, 8'h84};
    model_nal(pl, 1, 1'b1, tmp);
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
    set_in(8'h65, 1'b1, 1'b0); tick();
    check("lat_edge_n", 32'(bus.out_valid), 0);
    set_in(8'h88, 1'b1, 1'b0); tick();
    check("lat_edge_n1", 32'(bus.out_valid), 0);
    set_in(8'h84, 1'b1, 1'b1); tick();
    check("lat_edge_n2", 32'(bus.out_valid), 1);
    check("lat_first_byte", 32'(bus.out_byte), 0);
    set_in(8'h00, 1'b0, 1'b0);
    wait_drain("drain_single", 100);

    // emulation prevention, trailing zero and done-only endings
    pl = {8'h11, 8'h00, 8'h00, 8'h01}; send_nal(pl, 1); wait_drain("drain_epb1", 100);
    pl = {8'h00, 8'h00, 8'h00, 8'h00}; send_nal(pl, 1); wait_drain("drain_epb_zeros", 100);
    pl = {8'h00, 8'h00, 8'h04};        send_nal(pl, 1); wait_drain("drain_no_epb", 100);
    pl = {8'hAB, 8'h00};               send_nal(pl, 1); wait_drain("drain_trail0", 100);
    pl = {8'h12, 8'h34};               send_nal(pl, 2); wait_drain("drain_doneonly_nz", 100);
    pl = {8'h56, 8'h00};               send_nal(pl, 2); wait_drain("drain_doneonly_z", 100);

    set_in(8'h00, 1'b0, 1'b1); tick();
    set_in(8'h00, 1'b0, 1'b0);
    repeat (4) tick();
    check("empty_done_valid", 32'(bus.out_valid), 0);
    check("empty_done_level", 32'(bus.fifo_level), 0);

    // back-pressure, ready high one cycle in three
    rdy_mode = 1;
    pl = {};
    for (int i = 0; i < 40; i++) pl.push_back(rand_byte());
    send_nal(pl, 1);
    wait_drain("drain_bp", 400);
    check("bp_overflow", 32'(bus.overflow), 0);

    // random NALs under random ready
    rdy_mode = 3;
    for (int k = 0; k < 4; k++) begin
      pl = {};
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) pl.push_back(rand_byte());
      send_nal(pl, $urandom_range(1, 2));
      wait_drain("drain_rand", 300);
    end

    // overflow with the sink stalled
    rdy_mode = 2;
    tick();
    pl = {};
    for (int i = 0; i < 70; i++) pl.push_back(rand_byte());
    pl = pl[0:63];
    model_nal(pl, 0, 1'b1, tmp);
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
    for (int k = 1; k <= 70; k++) begin
      set_in((k <= 64) ? pl[k-1] : rand_byte(), 1'b1, 1'b0);
      tick();
      if (k == 64) begin
        check("ovf_level_64", 32'(bus.fifo_level), 64);
        check("ovf_flag_64", 32'(bus.overflow), 0);
      end
      if (k == 65) begin
        check("ovf_level_65", 32'(bus.fifo_level), 64);
        check("ovf_flag_65", 32'(bus.overflow), 1);
      end
    end
    set_in(8'h00, 1'b0, 1'b0);
    check("ovf_level_70", 32'(bus.fifo_level), 64);
    rdy_mode = 0;
    wait_drain("drain_ovf", 300);
    check("ovf_sticky", 32'(bus.overflow), 1);
    rst = 1'b0; tick();
    check("ovf_rst_clear", 32'(bus.overflow), 0);
    rst = 1'b1; tick();

    // reset mid-payload, then a fresh NAL
    pl = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    model_nal(pl, 0, 1'b1, tmp);
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
    for (int i = 0; i < 4; i++) begin
      set_in(pl[i], 1'b1, 1'b0);
      tick();
    end
    set_in(8'h00, 1'b0, 1'b0);
    rst = 1'b0; tick();
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_level", 32'(bus.fifo_level), 0);
    check("midrst_last", 32'(bus.out_last), 0);
    exp_q.delete();
    rst = 1'b1; tick();
    pl = {8'h55, 8'h66};
    send_nal(pl, 1);
    wait_drain("drain_after_rst", 100);

    // 3-byte start code instance
    pl = {8'h42};
    model_nal(pl, 1, 1'b0, tmp);
    foreach (tmp[i]) exp_s_q.push_back(tmp[i]);
    bus_s.in_byte = 8'h42; bus_s.in_strobe = 1'b1; bus_s.in_done = 1'b1;
    tick();
    bus_s.in_byte = 8'h00; bus_s.in_strobe = 1'b0; bus_s.in_done = 1'b0;
    n = 0;
    while ((exp_s_q.size() != 0 || bus_s.out_valid) && n < 50) begin
      tick();
      n++;
    end
    check("short_drained", 32'(exp_s_q.size()), 0);

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
